word_tokenizer: RTL and testbench
=================================

# word_tokenizer

Upstream lexer stage for the Forth dictionary. Consumes a character stream and splits it on whitespace into words packed as fixed-length, zero-padded key arrays, ready to drive the dictionary key input directly. Each completed word is held on a valid/ready output until the dictionary-op sequencer accepts it. Optionally classifies decimal literals so the sequencer can bypass the dictionary lookup for numbers.

## Interface
Parameters:
- KEY_WIDTH, 8: bits per character; matches the dictionary key width.
- KEY_LENGTH, 8: characters per key; matches the dictionary key length.
- VALUE_WIDTH, 32: width of the parsed numeric value.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset; synchronous and active-high.
- i_en  in  1  enable; when low, all state holds and no handshake completes.
- i_char_valid  in  1  upstream character present.
- i_char  in  KEY_WIDTH  character, ASCII.
- o_char_ready  out  1  character accepted this cycle when high with i_char_valid.
- o_key  out  KEY_WIDTH x KEY_LENGTH  word; o_key[0] is the first character; unused slots are 0.
- o_key_len  out  $clog2(KEY_LENGTH+1)  characters stored, 1..KEY_LENGTH.
- o_truncated  out  1  word was longer than KEY_LENGTH.
- o_is_number  out  1  word is a decimal literal (feature-dependent).
- o_number  out  VALUE_WIDTH  literal value, two's complement (feature-dependent).
- o_valid  out  1  token present.
- i_ready  in  1  downstream accepts the token.
- d_state  out  2  debug state.

## Operation
- Delimiters: 0x20, 0x09, 0x0A, 0x0D, 0x00. All other characters are word characters.
- Character accept: o_char_ready = i_en & ~i_rst & (d_state != EMIT). Transfer occurs when o_char_ready & i_char_valid.
- IDLE (0):
  - An accepted delimiter is discarded.
  - An accepted word character is written to key[0], sets len to 1, and moves to ACCUM.
- ACCUM (1):
  - An accepted word character with len < KEY_LENGTH is stored at key[len] and increments len.
  - An accepted word character with len == KEY_LENGTH is dropped and sets the truncated flag.
  - An accepted delimiter is consumed and moves to EMIT.
- EMIT (2):
  - o_valid is high. o_key, o_key_len, o_truncated, o_is_number and o_number are stable.
  - When i_ready & i_en: clear the key to all zeros, clear len, truncated and the number accumulator, then move to IDLE.
- Encoding 3 is unused; it recovers to IDLE.
- Reset values: o_valid 0, o_key all 0, o_key_len 0, o_truncated 0, o_is_number 0, o_number 0, d_state IDLE.
- Reset mid-word discards the partial word with no emission.
- End of input is signalled by an explicit 0x00 character, which flushes the final word.

## Timing
- Delimiter accepted in cycle N; o_valid high in cycle N+1.
- Token handshake in cycle M; o_valid low and o_char_ready high in cycle M+1.
- A character handshake and a token handshake never coincide, because o_char_ready is low in EMIT.
- Peak throughput: an n-character word costs n+1 character cycles plus 1 emit cycle.
- i_en low freezes the state machine and all outputs. o_valid stays asserted if already set.

## Configuration
- Macro: TOKEN_NUMBER_EN.
- Defined:
  - A running accumulator updates per stored character: acc = acc*10 + digit, modulo 2^VALUE_WIDTH.
  - '-' (0x2D) is allowed only at key[0].
  - o_is_number = 1 iff at least one digit is present, every character is a digit (apart from an optional leading '-'), and the word is not truncated.
  - o_number is acc, or -acc for a leading '-'. It is registered on entry to EMIT.
  - Overflow wraps silently.
- Undefined: o_is_number and o_number are tied to 0 and no accumulator logic is built. The port list is unchanged.

## Structure
- Package tokenizer_pkg holds:
  - state encodings IDLE/ACCUM/EMIT;
  - delimiter character constants;
  - ASCII '0', '9', '-'.
- Sub-module char_class (combinational) produces is_delim, is_digit and a 4-bit digit value from i_char.
- word_tokenizer holds the state machine, key registers and accumulator.

## Test plan
- "DUP " -> one token: key 'D','U','P',0,0,0,0,0; len 3; truncated 0.
- "  \t\nSWAP\r" -> exactly one token "SWAP", len 4; leading delimiters produce no token.
- "ABCDEFGHIJ " with KEY_LENGTH 8 -> key "ABCDEFGH", len 8, truncated 1.
- Token pending, i_ready held low 5 cycles:
  - o_valid stays 1 and o_key stays stable;
  - o_char_ready stays 0;
  - following "X " yields a clean "X", len 1, with no stale bytes.
- TOKEN_NUMBER_EN defined:
  - "-42 " -> is_number 1, o_number 0xFFFFFFD6;
  - "4a " -> is_number 0;
  - "- " -> is_number 0;
  - "123456789 " (9 chars) -> truncated 1, is_number 0.
- "AB", then i_rst high for 1 cycle, then "C " -> single token "C", len 1; all outputs 0 during reset.

Source files
------------

// File: rtl/word_tokenizer_pkg.sv
// rtl/word_tokenizer_pkg.sv - shared states and character constants for the word tokenizer
// Purpose: state encodings and the ASCII constants used by char_class and word_tokenizer.
package tokenizer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_TAB   = 8'h09;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_NUL   = 8'h00;
    localparam logic [7:0] CHAR_0     = 8'h30;
    localparam logic [7:0] CHAR_9     = 8'h39;
    localparam logic [7:0] CHAR_MINUS = 8'h2D;

endpackage

// File: rtl/word_tokenizer_if.sv
// rtl/word_tokenizer_if.sv - character stream in, token out, grouped as one bus
// Purpose: bundles the character handshake and the token handshake.
// slave  : tokenizer view (consumes i_char*, i_ready; drives o_*).
// master : environment view (drives i_char*, i_ready; observes o_*).
interface word_tokenizer_if #(
    parameter int KEY_WIDTH   = 8,
    parameter int KEY_LENGTH  = 8,
    parameter int VALUE_WIDTH = 32
);
    localparam int LEN_W = $clog2(KEY_LENGTH + 1);

    logic                                 i_char_valid;
    logic [KEY_WIDTH-1:0]                 i_char;
    logic                                 o_char_ready;
    logic [KEY_LENGTH-1:0][KEY_WIDTH-1:0] o_key;
    logic [LEN_W-1:0]                     o_key_len;
    logic                                 o_truncated;
    logic                                 o_is_number;
    logic [VALUE_WIDTH-1:0]               o_number;
    logic                                 o_valid;
    logic                                 i_ready;

    modport slave (
        input  i_char_valid, i_char, i_ready,
        output o_char_ready, o_key, o_key_len, o_truncated,
               o_is_number, o_number, o_valid
    );

    modport master (
        output i_char_valid, i_char, i_ready,
        input  o_char_ready, o_key, o_key_len, o_truncated,
               o_is_number, o_number, o_valid
    );
endinterface

// File: rtl/word_tokenizer_char_class.sv
// rtl/word_tokenizer_char_class.sv - combinational character classifier
// Purpose: flags whitespace/NUL delimiters and decimal digits.
// Ports: i_char (in), o_is_delim, o_is_digit, o_digit[3:0] (out).
module char_class
    import tokenizer_pkg::*;
#(
    parameter int KEY_WIDTH = 8
) (
    input  logic [KEY_WIDTH-1:0] i_char,
    output logic                 o_is_delim,
    output logic                 o_is_digit,
    output logic [3:0]           o_digit
);
    assign o_is_delim = (i_char == KEY_WIDTH'(CHAR_SPACE)) || (i_char == KEY_WIDTH'(CHAR_TAB)) ||
                        (i_char == KEY_WIDTH'(CHAR_LF))    || (i_char == KEY_WIDTH'(CHAR_CR))  ||
                        (i_char == KEY_WIDTH'(CHAR_NUL));

    assign o_is_digit = (i_char >= KEY_WIDTH'(CHAR_0)) && (i_char <= KEY_WIDTH'(CHAR_9));

    // '0' is 0x30, so the low nibble of a digit is its value.
    assign o_digit = i_char[3:0];
endmodule

// File: rtl/word_tokenizer.sv
// rtl/word_tokenizer.sv - splits a character stream into fixed-length zero-padded words
// Purpose: accumulates word characters into key slots, emits one token per word.
// Ports: i_clk, i_rst (sync, active-high), i_en (global hold), bus (word_tokenizer_if.slave:
//        char stream in, token out), d_state (debug FSM state).
// Option: TOKEN_NUMBER_EN builds the decimal literal classifier/accumulator.
module word_tokenizer
    import tokenizer_pkg::*;
#(
    parameter int KEY_WIDTH   = 8,
    parameter int KEY_LENGTH  = 8,
    parameter int VALUE_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    word_tokenizer_if.slave        bus,
    output logic [1:0]             d_state
);
    localparam int LEN_W = $clog2(KEY_LENGTH + 1);
    localparam int IDX_W = $clog2(KEY_LENGTH);

    state_t                               r_state, w_next;
    logic [KEY_LENGTH-1:0][KEY_WIDTH-1:0] r_key;
    logic [LEN_W-1:0]                     r_len;
    logic                                 r_trunc;

    logic       w_char_ready, w_xfer, w_tok_done, w_full, w_store, w_drop;
    logic       w_is_delim, w_is_digit;
    logic [3:0] w_digit;

    char_class #(.KEY_WIDTH(KEY_WIDTH)) u_char_class (
        .i_char     (bus.i_char),
        .o_is_delim (w_is_delim),
        .o_is_digit (w_is_digit),
        .o_digit    (w_digit)
    );

    assign w_full  = (r_len == LEN_W'(KEY_LENGTH));
    // IDLE has len 0, so key[len] is slot 0 there as well.
    assign w_store = w_xfer && !w_is_delim &&
                     ((r_state == ST_IDLE) || ((r_state == ST_ACCUM) && !w_full));
    assign w_drop  = w_xfer && !w_is_delim && (r_state == ST_ACCUM) && w_full;

    always_comb begin
        w_next       = r_state;
        w_char_ready = i_en && !i_rst && (r_state != ST_EMIT);
        w_xfer       = w_char_ready && bus.i_char_valid;
        w_tok_done   = i_en && bus.i_ready && (r_state == ST_EMIT);
        case (r_state)
            ST_IDLE:  if (w_xfer && !w_is_delim) w_next = ST_ACCUM;
            ST_ACCUM: if (w_xfer && w_is_delim)  w_next = ST_EMIT;
            ST_EMIT:  if (w_tok_done)            w_next = ST_IDLE;
            default:                             w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else if (i_en) begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_key   <= '0;
            r_len   <= '0;
            r_trunc <= 1'b0;
        end else if (i_en) begin
            if (w_tok_done) begin
                r_key   <= '0;
                r_len   <= '0;
                r_trunc <= 1'b0;
            end else begin
                if (w_store) begin
                    r_key[r_len[IDX_W-1:0]] <= bus.i_char;
                    r_len                   <= r_len + LEN_W'(1);
                end
                if (w_drop) r_trunc <= 1'b1;
            end
        end
    end

`ifdef TOKEN_NUMBER_EN
    logic [VALUE_WIDTH-1:0] r_acc, r_number;
    logic                   r_neg, r_has_digit, r_bad, r_is_number;
    logic                   w_enter_emit;

    assign w_enter_emit = w_xfer && w_is_delim && (r_state == ST_ACCUM);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc       <= '0;
            r_number    <= '0;
            r_neg       <= 1'b0;
            r_has_digit <= 1'b0;
            r_bad       <= 1'b0;
            r_is_number <= 1'b0;
        end else if (i_en) begin
            if (w_tok_done) begin
                r_acc       <= '0;
                r_number    <= '0;
                r_neg       <= 1'b0;
                r_has_digit <= 1'b0;
                r_bad       <= 1'b0;
                r_is_number <= 1'b0;
            end else begin
                if (w_store) begin
                    if (w_is_digit) begin
                        r_acc       <= r_acc * VALUE_WIDTH'(10) + VALUE_WIDTH'(w_digit);
                        r_has_digit <= 1'b1;
                    end else if ((bus.i_char == KEY_WIDTH'(CHAR_MINUS)) && (r_len == '0)) begin
                        r_neg <= 1'b1;
                    end else begin
                        r_bad <= 1'b1;
                    end
                end
                // Snapshot the classification as the word closes so EMIT outputs stay stable.
                if (w_enter_emit) begin
                    r_is_number <= r_has_digit && !r_bad && !r_trunc;
                    r_number    <= r_neg ? -r_acc : r_acc;
                end
            end
        end
    end

    assign bus.o_is_number = r_is_number;
    assign bus.o_number    = r_number;
`else
    logic w_unused_num;
    assign w_unused_num    = &{1'b0, w_is_digit, w_digit};
    assign bus.o_is_number = 1'b0;
    assign bus.o_number    = '0;
`endif

    assign bus.o_char_ready = w_char_ready;
    assign bus.o_key        = r_key;
    assign bus.o_key_len    = r_len;
    assign bus.o_truncated  = r_trunc;
    assign bus.o_valid      = (r_state == ST_EMIT);
    assign d_state          = r_state;
endmodule

// File: tb/tb_word_tokenizer.sv
// tb/tb_word_tokenizer.sv - directed self-checking bench for word_tokenizer
module tb_word_tokenizer;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] d_state;
    int         n_checks = 0;
    int         n_errors = 0;

    word_tokenizer_if #(.KEY_WIDTH(8), .KEY_LENGTH(8), .VALUE_WIDTH(32)) bus ();

    word_tokenizer #(.KEY_WIDTH(8), .KEY_LENGTH(8), .VALUE_WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .bus     (bus),
        .d_state (d_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] make_key(input string s);
        logic [63:0] k = '0;
        for (int i = 0; i < s.len() && i < 8; i++) k[i*8 +: 8] = s[i];
        return k;
    endfunction

    task automatic send_char(input logic [7:0] c);
        bit done = 0;
        bus.i_char_valid = 1'b1;
        bus.i_char       = c;
        for (int n = 0; n < 20 && !done; n++) begin
            if (bus.o_char_ready) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) check("char_timeout", 64'd0, 64'd1);
        bus.i_char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic expect_token(input string tag, input string s, input int len, input bit trunc);
        check({tag, "_valid"}, 64'(bus.o_valid), 64'd1);
        check({tag, "_key"},   bus.o_key, make_key(s));
        check({tag, "_len"},   64'(bus.o_key_len), 64'(len));
        check({tag, "_trunc"}, 64'(bus.o_truncated), 64'(trunc));
    endtask

    task automatic take_token(input string tag);
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        check({tag, "_valid_low"}, 64'(bus.o_valid), 64'd0);
        check({tag, "_cready"},    64'(bus.o_char_ready), 64'd1);
        check({tag, "_len_clr"},   64'(bus.o_key_len), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        bus.i_char_valid = 1'b0;
        bus.i_char       = 8'h00;
        bus.i_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",  64'(bus.o_valid), 64'd0);
        check("rst_key",    bus.o_key, 64'd0);
        check("rst_len",    64'(bus.o_key_len), 64'd0);
        check("rst_state",  64'(d_state), 64'd0);
        check("rst_cready", 64'(bus.o_char_ready), 64'd0);
        check("rst_num",    {31'd0, bus.o_is_number, bus.o_number}, 64'd0);
        rst = 1'b0;
        #1;

        // Basic word; valid must be up the cycle after the delimiter is accepted.
        send_str("DUP ");
        expect_token("dup", "DUP", 3, 0);
        take_token("dup");

        // Leading delimiters produce nothing, CR terminates.
        send_str("  \t\n");
        check("lead_novalid", 64'(bus.o_valid), 64'd0);
        check("lead_state",   64'(d_state), 64'd0);
        send_str("SWAP");
        send_char(8'h0D);
        expect_token("swap", "SWAP", 4, 0);
        take_token("swap");

        // Truncation.
        send_str("ABCDEFGHIJ ");
        expect_token("trunc", "ABCDEFGH", 8, 1);
        take_token("trunc");

        // Backpressure: token held, characters refused.
        send_str("HOLD ");
        bus.i_char_valid = 1'b1;
        bus.i_char       = "Z";
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid",  64'(bus.o_valid), 64'd1);
            check("hold_key",    bus.o_key, make_key("HOLD"));
            check("hold_cready", 64'(bus.o_char_ready), 64'd0);
        end
        bus.i_char_valid = 1'b0;
        take_token("hold");
        send_str("X ");
        expect_token("x", "X", 1, 0);

        // Enable low freezes a pending token even with ready high.
        en = 1'b0;
        bus.i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("en_valid", 64'(bus.o_valid), 64'd1);
        check("en_state", 64'(d_state), 64'd2);
        bus.i_ready = 1'b0;
        en = 1'b1;
        take_token("x");
        en = 1'b0;
        #1;
        check("en_cready", 64'(bus.o_char_ready), 64'd0);
        en = 1'b1;
        #1;

        // Literal classification (NUL flushes the last one).
        send_str("-42 ");
`ifdef TOKEN_NUMBER_EN
        check("neg_isnum", 64'(bus.o_is_number), 64'd1);
        check("neg_num",   64'(bus.o_number), 64'hFFFF_FFD6);
`else
        check("neg_isnum", 64'(bus.o_is_number), 64'd0);
        check("neg_num",   64'(bus.o_number), 64'd0);
`endif
        expect_token("neg", "-42", 3, 0);
        take_token("neg");
        send_str("4a ");
        check("4a_isnum", 64'(bus.o_is_number), 64'd0);
        take_token("4a");
        send_str("- ");
        check("dash_isnum", 64'(bus.o_is_number), 64'd0);
        take_token("dash");
        send_str("123456789");
        send_char(8'h00);
        check("big_isnum", 64'(bus.o_is_number), 64'd0);
        expect_token("big", "12345678", 8, 1);
        take_token("big");
`ifdef TOKEN_NUMBER_EN
        send_str("7 ");
        check("pos_isnum", 64'(bus.o_is_number), 64'd1);
        check("pos_num",   64'(bus.o_number), 64'd7);
        take_token("pos");
`endif

        // Reset mid-word discards the partial word.
        send_str("AB");
        rst = 1'b1;
        #1;
        check("mid_cready", 64'(bus.o_char_ready), 64'd0);
        @(posedge clk);
        #1;
        check("mid_valid", 64'(bus.o_valid), 64'd0);
        check("mid_key",   bus.o_key, 64'd0);
        check("mid_len",   64'(bus.o_key_len), 64'd0);
        check("mid_state", 64'(d_state), 64'd0);
        rst = 1'b0;
        #1;
        send_str("C ");
        expect_token("c", "C", 1, 0);
        take_token("c");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
